// File: rtl/adder_sched.sv
// adder_sched: round-robin operand collector and sequencer for the
// shared multi-operand registered adder.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_data  per-requester operand offers
//   req_ready           one-hot grant (COLLECT only)
//   flush               close a partial reduction early
//   add_ops             operand bank driven to the adder
//   add_sum             adder sum, ADD_LAT register stages after add_ops
//   res_valid/res_data  captured sum, held until res_ready
//   res_count           number of operands behind res_data
//   res_ready           result consumer accepts
//   busy                high while waiting on or presenting a result
module adder_sched #(
    parameter int N_REQ   = 4,
    parameter int NUM_OPS = 16,
    parameter int DATA_W  = 16,
    parameter int SUM_W   = 28,
    parameter int ADD_LAT = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*DATA_W-1:0]         req_data,
    output logic [N_REQ-1:0]                req_ready,
    input  logic                            flush,
    output logic [NUM_OPS*DATA_W-1:0]       add_ops,
    input  logic [SUM_W-1:0]                add_sum,
    output logic                            res_valid,
    output logic [SUM_W-1:0]                res_data,
    output logic [$clog2(NUM_OPS+1)-1:0]    res_count,
    input  logic                            res_ready,
    output logic                            busy
);

    localparam int CNT_W = $clog2(NUM_OPS + 1);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LAT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESULT  = 2'd2;

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [LAT_W-1:0]  r_lat;
    logic [DATA_W-1:0] r_bank [NUM_OPS];
    logic              r_res_valid;
    logic [SUM_W-1:0]  r_res_data;
    logic [CNT_W-1:0]  r_res_count;

    logic [DATA_W-1:0] w_req_data [N_REQ];
    logic [PTR_W-1:0]  w_cand;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_nxt_ptr;
    logic [N_REQ-1:0]  w_gnt;
    logic [DATA_W-1:0] w_data;
    logic              w_found;
    logic              w_collect;
    logic              w_xfer;
    logic              w_last;
    logic              w_close;
    logic              w_accept;

    // Unpack the flat requester bus so it can be indexed by pointer.
    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign w_req_data[g] = req_data[g*DATA_W +: DATA_W];
    end

    // The adder always sees the registered bank, never live request data.
    for (genvar g = 0; g < NUM_OPS; g++) begin : g_ops
        assign add_ops[g*DATA_W +: DATA_W] = r_bank[g];
    end

    function automatic logic [PTR_W-1:0] wrap_idx(
        input logic [PTR_W-1:0] p,
        input int               k
    );
        int s;
        s = (int'(p) + k) % N_REQ;
        return PTR_W'(s);
    endfunction

    // Search upward from the round-robin pointer for the first valid.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        w_gnt   = '0;
        w_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = wrap_idx(r_ptr, k);
            if (!w_found && req_valid[w_cand]) begin
                w_found       = 1'b1;
                w_idx         = w_cand;
                w_gnt[w_cand] = 1'b1;
                w_data        = w_req_data[w_cand];
            end
        end
    end

    assign w_collect = (r_state == S_COLLECT);

    // Grant is suppressed while reset is asserted even though the
    // state register already reads COLLECT.
    assign req_ready = (w_collect && rst_n) ? w_gnt : '0;

    assign w_xfer   = |(req_valid & req_ready);
    assign w_last   = w_xfer && (r_wr_cnt == CNT_W'(NUM_OPS - 1));
    assign w_close  = w_last
                    || (flush && ((r_wr_cnt != '0) || w_xfer));
    assign w_accept = (r_state == S_RESULT) && res_ready;

    assign w_nxt_ptr = (w_idx == PTR_W'(N_REQ - 1))
                     ? '0 : w_idx + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_COLLECT;
            r_ptr       <= '0;
            r_wr_cnt    <= '0;
            r_lat       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_count <= '0;
        end else begin
            unique case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        r_ptr    <= w_nxt_ptr;
                    end
                    if (w_close) begin
                        r_state <= S_WAIT;
                        r_lat   <= LAT_W'(ADD_LAT);
                    end
                end
                S_WAIT: begin
                    // Bank is frozen here; count out the adder pipeline.
                    if (r_lat == '0) begin
                        r_res_data  <= add_sum;
                        r_res_count <= r_wr_cnt;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_wr_cnt    <= '0;
                        r_state     <= S_COLLECT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    // Unfilled slots stay zero so a flushed reduction sums correctly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                r_bank[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                r_bank[k] <= '0;
            end
        end else if (w_xfer) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (r_wr_cnt == CNT_W'(k)) begin
                    r_bank[k] <= w_data;
                end
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_count = r_res_count;
    assign busy      = (r_state == S_WAIT) || (r_state == S_RESULT);

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: self-checking bench for adder_sched with a
// registered adder model and a result scoreboard.
module tb_adder_sched;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [63:0]   req_data;
    logic [3:0]    req_ready;
    logic          flush;
    logic [255:0]  add_ops;
    logic [27:0]   add_sum;
    logic          res_valid;
    logic [27:0]   res_data;
    logic [4:0]    res_count;
    logic          res_ready;
    logic          busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_ptr  = 0;

    typedef struct {
        logic [3:0]       mask;
        logic [3:0][15:0] base;
        bit               incr;
        int               n;
        int               mode;
        int               hold;
        logic [27:0]      exp_sum;
        logic [4:0]       exp_cnt;
    } vec_t;

    typedef struct {
        logic [27:0] sum;
        logic [4:0]  cnt;
    } res_t;

    vec_t tbl [6];
    res_t sb [$];

    adder_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .add_ops   (add_ops),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_count (res_count),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] ops_sum(input logic [255:0] o);
        logic [27:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) s += 28'(o[k*16 +: 16]);
        return s;
    endfunction

    // One-stage registered adder, as the real instance.
    always @(posedge clk) add_sum <= ops_sum(add_ops);

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_grant(input logic [3:0] m);
        int j;
        for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (m[j]) return 4'(1) << j;
        end
        return 4'd0;
    endfunction

    function automatic vec_t mk(input logic [3:0] mask,
                                input logic [63:0] base, input bit incr,
                                input int n, input int mode, input int hold,
                                input logic [27:0] es, input logic [4:0] ec);
        vec_t v;
        v.mask = mask;
        v.base = base;
        v.incr = incr;
        v.n = n;
        v.mode = mode;
        v.hold = hold;
        v.exp_sum = es;
        v.exp_cnt = ec;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int xf;
        int guard;
        int lat;
        int gi;
        int cnt [4];
        res_t e;
        sb.push_back('{sum: v.exp_sum, cnt: v.exp_cnt});
        res_ready = 1'b0;
        xf = 0;
        guard = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        while (xf < v.n && guard < 64) begin
            @(posedge clk); #2;
            req_valid = v.mask;
            for (int i = 0; i < 4; i++)
                req_data[i*16 +: 16] = v.base[i]
                    + (v.incr ? 16'(cnt[i]) : 16'd0);
            flush = (v.mode == 2) && (xf == v.n - 1);
            @(negedge clk);
            check("grant", 64'(req_ready), 64'(exp_grant(v.mask)));
            gi = -1;
            for (int i = 0; i < 4; i++) if (req_ready[i]) gi = i;
            if (gi >= 0) begin
                cnt[gi]++;
                xf++;
                m_ptr = (gi + 1) % 4;
            end
            guard++;
        end
        if (xf < v.n) check("collect_xfers", 64'(xf), 64'(v.n));
        @(posedge clk); #2;
        req_valid = '0;
        flush = (v.mode == 1);
        if (v.mode == 1) begin
            @(posedge clk); #2;
            flush = 1'b0;
        end
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (res_valid) break;
            lat++;
        end
        check("latency", 64'(lat), 64'd2);
        check("busy_result", 64'(busy), 64'd1);
        e = (sb.size() > 0) ? sb[0] : '{sum: '0, cnt: '0};
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #2;
            req_valid = v.mask;
            flush = 1'b1;
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_data", 64'(res_data), 64'(e.sum));
            check("hold_count", 64'(res_count), 64'(e.cnt));
            check("hold_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #2;
        req_valid = '0;
        flush = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check("res_data", 64'(res_data), 64'(e.sum));
                check("res_count", 64'(res_count), 64'(e.cnt));
            end
        end else begin
            check("handshake", 64'(res_valid), 64'd1);
        end
        @(posedge clk); #2;
        res_ready = 1'b0;
        @(negedge clk);
        check("bank_clear", 64'(|add_ops), 64'd0);
        check("valid_drop", 64'(res_valid), 64'd0);
        check("idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = mk(4'b1111, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0,
                    16, 0, 0, 28'd40, 5'd16);
        tbl[1] = mk(4'b0001, {48'd0, 16'd1}, 1'b1,
                    16, 0, 0, 28'd136, 5'd16);
        tbl[2] = mk(4'b0001, {48'd0, 16'hFFFF}, 1'b0,
                    5, 1, 0, 28'd327675, 5'd5);
        tbl[3] = mk(4'b0100, {16'd0, 16'hFFFF, 32'd0}, 1'b0,
                    5, 2, 0, 28'd327675, 5'd5);
        tbl[4] = mk(4'b1000, {16'hFFFF, 48'd0}, 1'b0,
                    16, 0, 10, 28'd1048560, 5'd16);
        tbl[5] = mk(4'b0010, {32'd0, 16'd2, 16'd0}, 1'b0,
                    16, 0, 0, 28'd32, 5'd16);

        rst_n = 1'b0;
        req_valid = 4'b1111;
        req_data = '0;
        flush = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_data", 64'(res_data), 64'd0);
        check("rst_count", 64'(res_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bank", 64'(|add_ops), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // Flush with an empty bank must be ignored.
        @(posedge clk); #2;
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        check("empty_flush_busy", 64'(busy), 64'd0);
        check("empty_flush_valid", 64'(res_valid), 64'd0);

        for (int t = 0; t < 5; t++) run_vec(tbl[t]);

        // Abort a partial reduction with reset.
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #2;
            req_valid = 4'b0001;
            req_data = 64'd9;
            @(negedge clk);
            check("abort_grant", 64'(req_ready), 64'(exp_grant(4'b0001)));
            if (req_ready[0]) m_ptr = 1;
        end
        @(posedge clk); #2;
        req_valid = 4'b1111;
        #4;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(req_ready), 64'd0);
        check("abort_bank", 64'(|add_ops), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(res_valid), 64'd0);
        repeat (2) @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        m_ptr = 0;

        run_vec(tbl[5]);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
